pwm_capture: RTL

- Downstream measurement stage for the PWM generator output.
- Samples an asynchronous PWM line and measures period and high time in clk cycles.
- Computes an 8-bit duty code, scaled 0..255 to match the generator's dutyCycle encoding, using an iterative divider.
- Feeds status/display logic and closed-loop checks of the generator settings.

---
 rtl/pwm_capture.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period / high-time / duty measurement stage
//
// Purpose:
//   Samples an asynchronous PWM line, measures period and high time in clk
//   cycles between consecutive rising edges, and derives an 8-bit (by
//   default) duty code floor(high*(2^DUTY_WIDTH-1)/period) with a restoring
//   divider that retires one quotient bit per cycle.
//
//   Optional build macro: PWM_CAPTURE_AVG_EN
//     When defined, four consecutive measurements are summed and divided by 4
//     (by shift) before the divider, so a result is produced once per four
//     periods.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   enable     in   measurement enable; low aborts and returns to IDLE
//   pwm_in     in   PWM line, asynchronous to clk
//   period     out  last measured period in clk cycles (0 after timeout)
//   high_time  out  last measured high time in clk cycles (0 after timeout)
//   duty       out  scaled duty code
//   valid      out  one-cycle pulse when period/high_time/duty update
//   timeout    out  line stuck; held until the next valid measurement
//   overrun    out  sticky; a measurement was dropped while the divider was busy

module pwm_capture #(
    parameter int CNT_WIDTH      = 32,
    parameter int DUTY_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  pwm_in,
    output logic [CNT_WIDTH-1:0]  period,
    output logic [CNT_WIDTH-1:0]  high_time,
    output logic [DUTY_WIDTH-1:0] duty,
    output logic                  valid,
    output logic                  timeout,
    output logic                  overrun
);

    localparam int NUM_W  = CNT_WIDTH + DUTY_WIDTH;
    localparam int STEP_W = (DUTY_WIDTH > 1) ? $clog2(DUTY_WIDTH) : 1;

    localparam logic [CNT_WIDTH-1:0]  TO_LIMIT  = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [DUTY_WIDTH-1:0] DUTY_FULL = '1;
    localparam logic [STEP_W-1:0]     STEP_LAST = STEP_W'(DUTY_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_DIVIDE,
        S_UPDATE
    } state_t;

    state_t r_state;

    // Input synchronizer; r_dly is the previous synchronized value so that
    // rise and fall are both detected with the same latency.
    logic r_sync1;
    logic r_sync2;
    logic r_dly;

    logic [CNT_WIDTH-1:0]  r_count;     // cycles since the last detected rise
    logic [CNT_WIDTH-1:0]  r_quiet;     // cycles since any detected edge
    logic                  r_to_done;   // timeout already reported for this stuck episode
    logic [CNT_WIDTH-1:0]  r_high_lat;  // high count latched at the falling edge

    logic [CNT_WIDTH-1:0]  r_per_snap;
    logic [CNT_WIDTH-1:0]  r_high_snap;
    logic [NUM_W-1:0]      r_num;
    logic [DUTY_WIDTH-1:0] r_quo;
    logic [STEP_W-1:0]     r_step;

`ifdef PWM_CAPTURE_AVG_EN
    logic [CNT_WIDTH+1:0]  r_acc_per;
    logic [CNT_WIDTH+1:0]  r_acc_high;
    logic [1:0]            r_acc_n;
    logic [CNT_WIDTH+1:0]  w_sum_per;
    logic [CNT_WIDTH+1:0]  w_sum_high;
`endif

    logic                  w_rise;
    logic                  w_fall;
    logic                  w_edge;
    logic [CNT_WIDTH-1:0]  w_count_next;
    logic [CNT_WIDTH-1:0]  w_quiet_next;
    logic                  w_to_hit;
    logic                  w_snap_go;
    logic [CNT_WIDTH-1:0]  w_snap_per;
    logic [CNT_WIDTH-1:0]  w_snap_high;
    logic [NUM_W-1:0]      w_num_init;
    logic [NUM_W-1:0]      w_den_sh;
    logic                  w_ge;

    assign w_rise = r_sync2 & ~r_dly;
    assign w_fall = ~r_sync2 & r_dly;
    assign w_edge = w_rise | w_fall;

    // Both counters saturate rather than wrap.
    assign w_count_next = (r_count == CNT_MAX) ? r_count : r_count + CNT_ONE;
    assign w_quiet_next = (r_quiet >= TO_LIMIT) ? TO_LIMIT : r_quiet + CNT_ONE;

    // Timeout fires once per stuck episode; any edge in the same cycle wins.
    assign w_to_hit = ~w_edge & ~r_to_done & (w_quiet_next == TO_LIMIT);

`ifdef PWM_CAPTURE_AVG_EN
    assign w_sum_per  = r_acc_per  + {2'b00, r_count};
    assign w_sum_high = r_acc_high + {2'b00, r_high_lat};
    assign w_snap_go   = (r_acc_n == 2'd3);
    assign w_snap_per  = w_sum_per[CNT_WIDTH+1:2];
    assign w_snap_high = w_sum_high[CNT_WIDTH+1:2];
`else
    assign w_snap_go   = 1'b1;
    assign w_snap_per  = r_count;
    assign w_snap_high = r_high_lat;
`endif

    // high * (2^DUTY_WIDTH - 1) without a multiplier.
    assign w_num_init = (NUM_W'(w_snap_high) << DUTY_WIDTH) - NUM_W'(w_snap_high);

    // Restoring division trial: compare against the divisor aligned to bit r_step.
    assign w_den_sh = NUM_W'(r_per_snap) << r_step;
    assign w_ge     = (r_num >= w_den_sh);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_dly       <= 1'b0;
            r_count     <= '0;
            r_quiet     <= '0;
            r_to_done   <= 1'b0;
            r_high_lat  <= '0;
            r_per_snap  <= '0;
            r_high_snap <= '0;
            r_num       <= '0;
            r_quo       <= '0;
            r_step      <= '0;
`ifdef PWM_CAPTURE_AVG_EN
            r_acc_per   <= '0;
            r_acc_high  <= '0;
            r_acc_n     <= '0;
`endif
            period      <= '0;
            high_time   <= '0;
            duty        <= '0;
            valid       <= 1'b0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
            valid   <= 1'b0;

            if (!enable) begin
                // Abort everything; published results are left untouched.
                r_state    <= S_IDLE;
                r_count    <= '0;
                r_quiet    <= '0;
                r_to_done  <= 1'b0;
                r_high_lat <= '0;
                overrun    <= 1'b0;
`ifdef PWM_CAPTURE_AVG_EN
                r_acc_per  <= '0;
                r_acc_high <= '0;
                r_acc_n    <= '0;
`endif
            end else begin
                if (w_edge) begin
                    r_quiet   <= '0;
                    r_to_done <= 1'b0;
                end else begin
                    r_quiet <= w_quiet_next;
                end

                // The period count restarts on every rise, including rises
                // dropped while the divider is busy, so the next accepted
                // measurement still covers exactly one period.
                if (w_rise) begin
                    r_count    <= CNT_ONE;
                    r_high_lat <= '0;
                end else begin
                    r_count <= w_count_next;
                    if (w_fall) begin
                        r_high_lat <= r_count;
                    end
                end

                case (r_state)
                    S_IDLE: begin
                        r_state <= S_ARM;
                    end

                    S_ARM, S_MEASURE: begin
                        if (w_rise) begin
                            if (r_state == S_ARM) begin
                                // First rise only opens a measurement window.
                                r_state <= S_MEASURE;
                            end else begin
`ifdef PWM_CAPTURE_AVG_EN
                                if (w_snap_go) begin
                                    r_acc_per  <= '0;
                                    r_acc_high <= '0;
                                    r_acc_n    <= '0;
                                end else begin
                                    r_acc_per  <= w_sum_per;
                                    r_acc_high <= w_sum_high;
                                    r_acc_n    <= r_acc_n + 2'd1;
                                end
`endif
                                if (w_snap_go) begin
                                    r_per_snap  <= w_snap_per;
                                    r_high_snap <= w_snap_high;
                                    r_num       <= w_num_init;
                                    r_quo       <= '0;
                                    r_step      <= STEP_LAST;
                                    r_state     <= S_DIVIDE;
                                end
                            end
                        end else if (w_to_hit) begin
                            period     <= '0;
                            high_time  <= '0;
                            duty       <= r_sync2 ? DUTY_FULL : '0;
                            valid      <= 1'b1;
                            timeout    <= 1'b1;
                            r_to_done  <= 1'b1;
                            r_count    <= '0;
                            r_high_lat <= '0;
`ifdef PWM_CAPTURE_AVG_EN
                            r_acc_per  <= '0;
                            r_acc_high <= '0;
                            r_acc_n    <= '0;
`endif
                            r_state    <= S_ARM;
                        end
                    end

                    S_DIVIDE: begin
                        if (w_rise) begin
                            overrun <= 1'b1;
                        end
                        if (w_ge) begin
                            r_num        <= r_num - w_den_sh;
                            r_quo[r_step] <= 1'b1;
                        end
                        if (r_step == '0) begin
                            r_state <= S_UPDATE;
                        end else begin
                            r_step <= r_step - 1'b1;
                        end
                    end

                    S_UPDATE: begin
                        if (w_rise) begin
                            overrun <= 1'b1;
                        end
                        period    <= r_per_snap;
                        high_time <= r_high_snap;
                        duty      <= r_quo;
                        valid     <= 1'b1;
                        timeout   <= 1'b0;
                        r_state   <= S_MEASURE;
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
